// File: rtl/snd_dma_pkg.sv
// Shared definitions for the sound DMA address generator: address width,
// CPU register indices, control bit positions and byte-lane selector.
package snd_dma_pkg;

  localparam int AW = 22;

  localparam logic [3:0] SND_CTRL    = 4'd0;
  localparam logic [3:0] SND_START_H = 4'd1;
  localparam logic [3:0] SND_START_M = 4'd2;
  localparam logic [3:0] SND_START_L = 4'd3;
  localparam logic [3:0] SND_COUNT_H = 4'd4;
  localparam logic [3:0] SND_COUNT_M = 4'd5;
  localparam logic [3:0] SND_COUNT_L = 4'd6;
  localparam logic [3:0] SND_END_H   = 4'd7;
  localparam logic [3:0] SND_END_M   = 4'd8;
  localparam logic [3:0] SND_END_L   = 4'd9;

  localparam int CTRL_SNDON = 0;
  localparam int CTRL_SFREP = 1;

  typedef enum logic [1:0] {
    SEL_HI  = 2'd0,
    SEL_MID = 2'd1,
    SEL_LO  = 2'd2
  } byte_sel_e;

endpackage

// File: rtl/snd_dma_addr_if.sv
// CPU register bus of the sound DMA address generator.
interface snd_dma_addr_if;
  logic       cpu_sel;
  logic       cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  modport master (output cpu_sel, cpu_we, cpu_addr, cpu_din, input cpu_dout);
  modport slave  (input cpu_sel, cpu_we, cpu_addr, cpu_din, output cpu_dout);
endinterface

// File: rtl/snd_addr_reg.sv
// AW-bit register written one byte lane at a time or loaded whole, with a
// byte read mux. The hi lane holds bits AW-1:16; its spare upper bits read 0.
module snd_addr_reg
  import snd_dma_pkg::*;
(
  input  logic          clk,
  input  logic          porb,
  input  logic          we_hi,
  input  logic          we_mid,
  input  logic          we_lo,
  input  logic [7:0]    din,
  input  logic          ld,
  input  logic [AW-1:0] ld_val,
  input  byte_sel_e     rsel,
  output logic [AW-1:0] q,
  output logic [7:0]    rdata
);

  logic [AW-1:0] val_q, val_d;
  logic          unused_din;

  assign unused_din = ^din[7:AW-16];

  always_comb begin
    val_d = val_q;
    if (ld) begin
      val_d = ld_val;
    end else begin
      if (we_hi)  val_d[AW-1:16] = din[AW-17:0];
      if (we_mid) val_d[15:8]    = din;
      if (we_lo)  val_d[7:0]     = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!porb) val_q <= '0;
    else       val_q <= val_d;
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      SEL_HI:  rdata = 8'(val_q[AW-1:16]);
      SEL_MID: rdata = val_q[15:8];
      default: rdata = val_q[7:0];
    endcase
  end

  assign q = val_q;

endmodule

// File: rtl/snd_dma_addr.sv
// Sound DMA address generator: CPU control/start/end registers and the sound
// address counter. Define SND_DBUF_EN to double-buffer start/end until frame load.
module snd_dma_addr
  import snd_dma_pkg::*;
(
  input  logic           clk,
  input  logic           porb,
  snd_dma_addr_if.slave  cpu,
  input  logic           sndclk,
  input  logic           sframe,
  input  logic           stoff,
  output logic [AW-1:0]  snd,
  output logic [AW-1:0]  sft,
  output logic           sndon,
  output logic           sfrep
);

  logic          rd_stb, wr_stb, ctrl_wr, snap_ld, frame_ld, sndclk_rise;
  byte_sel_e     rsel;
  logic [AW-1:0] start_val, end_val, snap_val, ld_src;
  logic [7:0]    start_rd, end_rd, snap_rd;

  logic [AW-1:0] snd_q, snd_d;
  logic          sndon_q, sndon_d, sfrep_q, sfrep_d, sndclk_q, sndclk_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;

  assign rd_stb  = cpu.cpu_sel & ~cpu.cpu_we;
  assign wr_stb  = cpu.cpu_sel & cpu.cpu_we;
  assign ctrl_wr = wr_stb & (cpu.cpu_addr == SND_CTRL);
  assign snap_ld = rd_stb & (cpu.cpu_addr == SND_COUNT_H);

  always_comb begin
    rsel = SEL_LO;
    case (cpu.cpu_addr)
      SND_START_H, SND_COUNT_H, SND_END_H: rsel = SEL_HI;
      SND_START_M, SND_COUNT_M, SND_END_M: rsel = SEL_MID;
      default:                             rsel = SEL_LO;
    endcase
  end

  // In the double-buffered build these are the shadows; otherwise the live values.
  snd_addr_reg u_start (
    .clk(clk), .porb(porb),
    .we_hi (wr_stb & (cpu.cpu_addr == SND_START_H)),
    .we_mid(wr_stb & (cpu.cpu_addr == SND_START_M)),
    .we_lo (wr_stb & (cpu.cpu_addr == SND_START_L)),
    .din(cpu.cpu_din), .ld(1'b0), .ld_val('0), .rsel(rsel),
    .q(start_val), .rdata(start_rd)
  );

  snd_addr_reg u_end (
    .clk(clk), .porb(porb),
    .we_hi (wr_stb & (cpu.cpu_addr == SND_END_H)),
    .we_mid(wr_stb & (cpu.cpu_addr == SND_END_M)),
    .we_lo (wr_stb & (cpu.cpu_addr == SND_END_L)),
    .din(cpu.cpu_din), .ld(1'b0), .ld_val('0), .rsel(rsel),
    .q(end_val), .rdata(end_rd)
  );

  // Count hi read captures the whole counter so mid/lo reads are coherent.
  snd_addr_reg u_snap (
    .clk(clk), .porb(porb),
    .we_hi(1'b0), .we_mid(1'b0), .we_lo(1'b0),
    .din(cpu.cpu_din), .ld(snap_ld), .ld_val(snd_q), .rsel(rsel),
    .q(snap_val), .rdata(snap_rd)
  );

  logic unused_snap;
  assign unused_snap = ^snap_val;

  assign frame_ld    = (ctrl_wr & cpu.cpu_din[CTRL_SNDON] & ~sndon_q) | (~sframe & sndon_q);
  assign sndclk_rise = ~sndclk_q & sndclk;

`ifdef SND_DBUF_EN
  logic [AW-1:0] start_act_q, start_act_d, sft_q, sft_d;
  logic          unused_start_act;

  assign unused_start_act = ^start_act_q;
  assign ld_src = start_val;
  assign sft    = sft_q;

  always_comb begin
    start_act_d = start_act_q;
    sft_d       = sft_q;
    if (frame_ld) begin
      start_act_d = start_val;
      sft_d       = end_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!porb) begin
      start_act_q <= '0;
      sft_q       <= '0;
    end else begin
      start_act_q <= start_act_d;
      sft_q       <= sft_d;
    end
  end
`else
  assign ld_src = start_val;
  assign sft    = end_val;
`endif

  always_comb begin
    snd_d      = snd_q;
    sndon_d    = sndon_q;
    sfrep_d    = sfrep_q;
    sndclk_d   = sndclk;
    cpu_dout_d = cpu_dout_q;

    // A control write outranks a stop request in the same cycle.
    if (ctrl_wr) begin
      sndon_d = cpu.cpu_din[CTRL_SNDON];
      sfrep_d = cpu.cpu_din[CTRL_SFREP];
    end else if (stoff) begin
      sndon_d = 1'b0;
    end

    if (frame_ld)                  snd_d = ld_src;
    else if (sndclk_rise & sndon_q) snd_d = snd_q + AW'(1);

    if (rd_stb) begin
      case (cpu.cpu_addr)
        SND_CTRL:                            cpu_dout_d = 8'({sfrep_q, sndon_q});
        SND_START_H, SND_START_M, SND_START_L: cpu_dout_d = start_rd;
        SND_COUNT_H:                         cpu_dout_d = 8'(snd_q[AW-1:16]);
        SND_COUNT_M, SND_COUNT_L:            cpu_dout_d = snap_rd;
        SND_END_H, SND_END_M, SND_END_L:     cpu_dout_d = end_rd;
        default:                             cpu_dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!porb) begin
      snd_q      <= '0;
      sndon_q    <= 1'b0;
      sfrep_q    <= 1'b0;
      sndclk_q   <= 1'b1;
      cpu_dout_q <= '0;
    end else begin
      snd_q      <= snd_d;
      sndon_q    <= sndon_d;
      sfrep_q    <= sfrep_d;
      sndclk_q   <= sndclk_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  assign snd          = snd_q;
  assign sndon        = sndon_q;
  assign sfrep        = sfrep_q;
  assign cpu.cpu_dout = cpu_dout_q;

endmodule

// File: tb/tb_snd_dma_addr.sv
// Bench for snd_dma_addr: directed register-map scenarios, then random traffic,
// all compared each cycle against a register-level reference model.
module tb_snd_dma_addr;

  logic        clk = 1'b0;
  logic        porb, sndclk, sframe, stoff;
  logic [21:0] snd, sft;
  logic        sndon, sfrep;

  snd_dma_addr_if bus ();

  snd_dma_addr dut (
    .clk(clk), .porb(porb), .cpu(bus),
    .sndclk(sndclk), .sframe(sframe), .stoff(stoff),
    .snd(snd), .sft(sft), .sndon(sndon), .sfrep(sfrep)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  // Reference model: architectural registers of the block.
  logic [21:0] m_snd, m_act_start, m_sft, m_sh_start, m_sh_end, m_snap;
  logic        m_on, m_rep, m_prev;
  logic [7:0]  m_dout;

`ifdef SND_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  // Byte k of a register as seen on the bus: 0 = hi, 1 = mid, 2 = lo.
  function automatic logic [7:0] byte_of(logic [21:0] v, int k);
    return 8'((int'(v) >> (8 * (2 - k))) & 255);
  endfunction

  function automatic logic [21:0] put_byte(logic [21:0] v, int k, logic [7:0] d);
    logic [23:0] w;
    w = {2'b00, v};
    w[8 * (2 - k) +: 8] = d;
    return w[21:0];
  endfunction

  task automatic model_step();
    logic [21:0] n_snd, n_start, n_sft, n_sh_s, n_sh_e, n_snap, start_view, end_view;
    logic        n_on, n_rep, ctrl_wr, ld, rise;
    int          a;
    if (!porb) begin
      m_snd = 0; m_act_start = 0; m_sft = 0; m_sh_start = 0; m_sh_end = 0;
      m_snap = 0; m_on = 0; m_rep = 0; m_prev = 1; m_dout = 0;
      return;
    end
    a = int'(bus.cpu_addr);
    n_snd = m_snd; n_start = m_act_start; n_sft = m_sft;
    n_sh_s = m_sh_start; n_sh_e = m_sh_end; n_snap = m_snap;
    n_on = m_on; n_rep = m_rep;
    rise = !m_prev && sndclk;
    start_view = DBUF ? m_sh_start : m_act_start;
    end_view   = DBUF ? m_sh_end   : m_sft;
    ctrl_wr = bus.cpu_sel && bus.cpu_we && a == 0;
    ld = (ctrl_wr && bus.cpu_din[0] && !m_on) || (!sframe && m_on);

    if (bus.cpu_sel && !bus.cpu_we) begin
      if (a == 0)                m_dout = {6'b0, m_rep, m_on};
      else if (a >= 1 && a <= 3) m_dout = byte_of(start_view, a - 1);
      else if (a == 4) begin     m_dout = byte_of(m_snd, 0); n_snap = m_snd; end
      else if (a == 5 || a == 6) m_dout = byte_of(m_snap, a - 4);
      else if (a >= 7 && a <= 9) m_dout = byte_of(end_view, a - 7);
      else                       m_dout = 8'h00;
    end

    if (bus.cpu_sel && bus.cpu_we) begin
      if (a == 0) begin
        n_on = bus.cpu_din[0]; n_rep = bus.cpu_din[1];
      end else if (a >= 1 && a <= 3) begin
        if (DBUF) n_sh_s  = put_byte(m_sh_start, a - 1, bus.cpu_din);
        else      n_start = put_byte(m_act_start, a - 1, bus.cpu_din);
      end else if (a >= 7 && a <= 9) begin
        if (DBUF) n_sh_e = put_byte(m_sh_end, a - 7, bus.cpu_din);
        else      n_sft  = put_byte(m_sft, a - 7, bus.cpu_din);
      end
    end
    if (!ctrl_wr && stoff) n_on = 0;

    if (ld) begin
      if (DBUF) begin n_snd = m_sh_start; n_start = m_sh_start; n_sft = m_sh_end; end
      else            n_snd = m_act_start;
    end else if (rise && m_on) begin
      n_snd = 22'((int'(m_snd) + 1) % 4194304);
    end

    m_prev = sndclk;
    m_snd = n_snd; m_act_start = n_start; m_sft = n_sft;
    m_sh_start = n_sh_s; m_sh_end = n_sh_e; m_snap = n_snap;
    m_on = n_on; m_rep = n_rep;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk({phase, ":snd"},   32'(snd),          32'(m_snd));
    chk({phase, ":sft"},   32'(sft),          32'(m_sft_view()));
    chk({phase, ":sndon"}, 32'(sndon),        32'(m_on));
    chk({phase, ":sfrep"}, 32'(sfrep),        32'(m_rep));
    chk({phase, ":dout"},  32'(bus.cpu_dout), 32'(m_dout));
  endtask

  function automatic logic [21:0] m_sft_view();
    return m_sft;
  endfunction

  task automatic wr(logic [3:0] a, logic [7:0] d);
    bus.cpu_sel = 1; bus.cpu_we = 1; bus.cpu_addr = a; bus.cpu_din = d;
    tick();
    bus.cpu_sel = 0; bus.cpu_we = 0;
  endtask

  task automatic rd(logic [3:0] a);
    bus.cpu_sel = 1; bus.cpu_we = 0; bus.cpu_addr = a;
    tick();
    bus.cpu_sel = 0;
  endtask

  task automatic pulse();
    sndclk = 0; tick();
    sndclk = 1; tick();
  endtask

  initial begin
    porb = 0; sndclk = 1; sframe = 1; stoff = 0;
    bus.cpu_sel = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_din = 0;

    phase = "reset";
    tick(); tick();
    porb = 1;
    tick();
    chk("reset_snd", 32'(snd), 32'h0);
    chk("reset_sft", 32'(sft), 32'h0);
    chk("reset_sndon", 32'(sndon), 32'h0);
    rd(4'd4); chk("reset_cnt_h", 32'(bus.cpu_dout), 32'h00);
    rd(4'd5); chk("reset_cnt_m", 32'(bus.cpu_dout), 32'h00);
    rd(4'd6); chk("reset_cnt_l", 32'(bus.cpu_dout), 32'h00);

    phase = "program";
    wr(4'd1, 8'h01); wr(4'd2, 8'h23); wr(4'd3, 8'h40);
    wr(4'd7, 8'h01); wr(4'd8, 8'h23); wr(4'd9, 8'h44);
    wr(4'd0, 8'h03);
    chk("start_snd", 32'(snd), 32'h012340);
    chk("start_sft", 32'(sft), 32'h012344);
    chk("start_sndon", 32'(sndon), 32'h1);
    for (int i = 0; i < 4; i++) pulse();
    chk("run4_snd", 32'(snd), 32'h012344);
    rd(4'd0); chk("ctrl_read", 32'(bus.cpu_dout), 32'h03);

    phase = "repeat";
    sndclk = 0; tick();
    sndclk = 1; sframe = 0; tick();
    sframe = 1;
    chk("reload_no_inc", 32'(snd), 32'h012340);
    wr(4'd1, 8'h02); wr(4'd2, 8'h00); wr(4'd3, 8'h00);
    chk("midframe_start_hold", 32'(snd), 32'h012340);
    sframe = 0; tick(); sframe = 1;
    chk("reload_new_start", 32'(snd), 32'h020000);

    phase = "single";
    wr(4'd0, 8'h01);
    chk("on_again_no_load", 32'(snd), 32'h020000);
    pulse();
    stoff = 1; tick(); stoff = 0;
    chk("stop_sndon", 32'(sndon), 32'h0);
    chk("stop_snd_hold", 32'(snd), 32'h020001);
    pulse(); pulse();
    chk("frozen_snd", 32'(snd), 32'h020001);
    stoff = 1; wr(4'd0, 8'h01); stoff = 0;
    chk("ctrl_beats_stoff", 32'(sndon), 32'h1);
    chk("ctrl_stoff_reload", 32'(snd), 32'h020000);

    phase = "wrap";
    wr(4'd1, 8'hFF); wr(4'd2, 8'hFF); wr(4'd3, 8'hFE);
    rd(4'd1); chk("hi_byte_masked", 32'(bus.cpu_dout), 32'h3F);
    sframe = 0; tick(); sframe = 1;
    chk("wrap_load", 32'(snd), 32'h3FFFFE);
    pulse(); chk("wrap_1", 32'(snd), 32'h3FFFFF);
    pulse(); chk("wrap_2", 32'(snd), 32'h000000);
    pulse(); chk("wrap_3", 32'(snd), 32'h000001);
    rd(4'd4); chk("snap_hi", 32'(bus.cpu_dout), 32'h00);
    pulse();
    rd(4'd5); chk("snap_mid", 32'(bus.cpu_dout), 32'h00);
    rd(4'd6); chk("snap_lo", 32'(bus.cpu_dout), 32'h01);
    rd(4'd12); chk("unmapped_read", 32'(bus.cpu_dout), 32'h00);

    phase = "end_write";
    wr(4'd9, 8'h55);
`ifdef SND_DBUF_EN
    chk("end_write_deferred", 32'(sft), 32'h012344);
`else
    chk("end_write_direct", 32'(sft), 32'h012355);
`endif

    phase = "reset_mid";
    sndclk = 0; porb = 0; tick();
    porb = 1; sndclk = 1; tick();
    chk("rst_mid_snd", 32'(snd), 32'h0);
    chk("rst_mid_sndon", 32'(sndon), 32'h0);
    rd(4'd7); chk("rst_mid_end", 32'(bus.cpu_dout), 32'h00);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      bus.cpu_sel  = ($urandom_range(0, 2) == 0);
      bus.cpu_we   = 1'($urandom_range(0, 1));
      bus.cpu_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 9));
      bus.cpu_din  = 8'($urandom);
      if (bus.cpu_addr == 4'd0 && bus.cpu_we) bus.cpu_din[0] = ($urandom_range(0, 3) != 0);
      sndclk = 1'($urandom_range(0, 1));
      sframe = ($urandom_range(0, 15) != 0);
      stoff  = ($urandom_range(0, 23) == 0);
      porb   = ($urandom_range(0, 299) != 0);
      tick();
    end

    bus.cpu_sel = 0; porb = 1; sframe = 1; stoff = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snd_dma_addr.md
Name: snd_dma_addr

Overview:
- Sound DMA address generator for the sound/video DMA control path.
- Holds the CPU-visible sound control, frame-start and frame-end registers, and runs the 22-bit sound address counter.
- Drives `snd` (current address), `sft` (frame end), `sndon` and `sfrep` into the DMA control block.
- Consumes that block's `sndclk`, `sframe` and `stoff` to advance, reload or stop.

Parameters:
- AW, 22, address width of counter/start/end (word address units).

Ports:
- clk  in  1  system clock
- porb  in  1  reset, synchronous, active-low
- cpu_sel  in  1  register access strobe, one cycle per access
- cpu_we  in  1  1 = write, 0 = read (qualified by cpu_sel)
- cpu_addr  in  4  register index
- cpu_din  in  8  write data
- cpu_dout  out  8  read data, registered
- sndclk  in  1  active-low sound DMA cycle strobe from control block
- sframe  in  1  active-low frame-reload request (repeat mode end match)
- stoff  in  1  active-high stop request (single-shot end match)
- snd  out  AW  current sound address
- sft  out  AW  active frame end address
- sndon  out  1  sound DMA enable
- sfrep  out  1  frame repeat mode

Behaviour:
- Clocking and reset:
  - All state changes on posedge clk. Reset is synchronous: `porb`=0 at posedge.
  - Reset clears every register, so `snd`, `sft`, start, end, `cpu_dout`, `sndon`, `sfrep` and the edge-detect flop (set to 1) all take their reset values.
- Register map (`cpu_addr`):
  - 0 control: bit0 `sndon`, bit1 `sfrep`, bits 7:2 read 0.
  - 1/2/3 start hi/mid/lo.
  - 4/5/6 count hi/mid/lo, read-only; writes ignored.
  - 7/8/9 end hi/mid/lo.
  - 10-15 read 0, writes ignored.
  - Hi byte carries bits 21:16 in its low 6 bits; upper 2 bits read 0 and are ignored on write.
- Reads:
  - `cpu_dout` updates the cycle after `cpu_sel`&~`cpu_we` and holds otherwise (1-cycle latency).
  - Reading count hi snapshots the full counter into a 22-bit latch; count mid/lo reads return the latch, giving a coherent readback.
  - Mid/lo reads without a prior hi read return the last snapshot.
- Start/end programming:
  - CPU writes land in shadow registers `start_sh`/`end_sh`.
  - The active frame start (`start_act`) and `sft` are loaded from the shadows only at a frame load (see below).
- Frame load occurs on either:
  - (a) `sndon` transition 0→1 by CPU write; or
  - (b) `sframe`=0 while `sndon`=1.
  - Effect: `snd` ← `start_sh`, `start_act` ← `start_sh`, `sft` ← `end_sh`, all in the same cycle.
  - Writing `sndon`=1 while already 1 causes no load.
- Advance:
  - `sndclk` is registered each cycle.
  - A rising edge (previous 0, current 1) while `sndon`=1 gives `snd` ← `snd`+1 modulo 2^AW; 3FFFFF wraps to 0.
- Stop:
  - `stoff`=1 clears `sndon` next edge.
  - `snd`, `sft` and `sfrep` hold.
  - Counter frozen while `sndon`=0.
- Priorities in one cycle:
  - Reset > CPU control write > `stoff`. A control write setting `sndon` in the same cycle as `stoff` leaves `sndon`=1 and performs a frame load.
  - Frame load > advance. A reload coinciding with an `sndclk` edge yields `snd`=`start_sh`, with no increment.
  - A shadow write in the same cycle as a frame load: the load uses the old shadow value, and the new value takes effect at the next load.
- Reset mid-frame: counter, shadows and control all cleared; no residual edge detected after reset.

Optional Feature:
- `SND_DBUF_EN` defined: double-buffered behaviour as above.
- Undefined:
  - Start/end writes go directly to `start_act`/`sft`. Shadows are not implemented; start/end read back the active values.
  - A frame load copies `start_act` into `snd` only.
  - A mid-frame end write takes effect immediately on the end comparison downstream.

Decomposition:
- Shared package `snd_dma_pkg`:
  - register index constants (`SND_CTRL`, `SND_START_H`…`SND_END_L`);
  - AW localparam;
  - control bit positions.
- One natural sub-module, `snd_addr_reg`:
  - a 22-bit byte-addressable register with hi/mid/lo write enables and read mux;
  - instantiated for start, end and the count snapshot.

Test Plan:
- Reset → `snd`=0, `sft`=0, `sndon`=0, `sfrep`=0, `cpu_dout`=0; read count hi/mid/lo → 00/00/00.
- Write start=012340, end=012344, control=03 → next cycle `snd`=012340, `sft`=012344, `sndon`=1; 4 `sndclk` low-high pulses → `snd`=012344.
- Repeat mode: with `sndon`=1, pulse `sframe` low one cycle coinciding with a `sndclk` rising edge → `snd`=start_sh, no increment. Writing start=020000 mid-frame leaves `snd` unaffected until the next `sframe`.
- Single-shot: control=01, drive `stoff`=1 → `sndon`=0 next cycle, `snd` holds; further `sndclk` pulses leave `snd` unchanged. Control write 01 in the same cycle as `stoff` → `sndon` stays 1 and `snd` reloads.
- Wrap: start=3FFFFE, run 3 `sndclk` edges → `snd` 3FFFFF, 000000, 000001. Read count hi, advance once, read mid/lo → snapshot values, not live.
- With `SND_DBUF_EN` undefined: write end lo mid-frame → `sft` changes the next cycle without reload.
